spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4, meaning the highest writable register address.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-005 SHALL have port copi  input  1  SPI controller-out data, asynchronous.
REQ-006 SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port cipo  output  1  SPI controller-in data; used only with readback (REQ-027).
REQ-008 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  register values at addresses 0x00-0x04, feeding the PWM peripheral.
REQ-009 SHALL have port wr_strobe  output  1  one-cycle pulse on each committed write.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on each discarded frame.

Function
REQ-011 SHALL pass sclk, copi and ncs each through a 2-flop synchronizer, plus one more flop for edge detection on sclk and ncs.
REQ-012 SHALL begin a frame on a synchronized ncs falling edge: bit counter 0, shift register 0, overflow flag 0.
REQ-013 SHALL, on each synchronized sclk rising edge while synchronized ncs is low, shift synchronized copi into a 16-bit shift register, MSB first.
REQ-014 SHALL increment the bit counter per sampled bit, saturating at 16; a 17th bit sets the overflow flag.
REQ-015 SHALL decode the frame as: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
REQ-016 SHALL end a frame on a synchronized ncs rising edge and evaluate it in the same clk cycle.
REQ-017 SHALL commit a frame only if counter == 16, overflow = 0, R/W = 1 and address <= MAX_ADDR.
REQ-018 SHALL, on commit, load data into the addressed register and assert wr_strobe for exactly one cycle.
REQ-019 SHALL make a committed value visible on its output no later than 3 clk rising edges after the ncs pin rises.
REQ-020 SHALL, for any other write-type frame (short, long, or address > MAX_ADDR), leave all registers unchanged and pulse frame_err for one cycle.
REQ-021 SHALL ignore sclk edges while synchronized ncs is high.
REQ-022 SHALL hold all register outputs stable between commits; unaddressed registers never change.
REQ-023 SHALL require clk >= 4x sclk frequency; behaviour outside this limit is undefined.

Reset
REQ-024 SHALL, while rst = 1 at a clk edge, clear all five registers to 0x00 and clear the synchronizers, counter, shift register and overflow flag to 0; wr_strobe, frame_err and cipo are 0.
REQ-025 SHALL discard a frame in progress when reset is asserted; no commit occurs for that frame after reset is released.
REQ-026 SHALL treat ncs already low when reset is released as no frame; a frame starts only on a new falling edge.

Configuration
REQ-027 SHALL, when SPI_READBACK_EN is defined, handle frames with R/W = 0 and address <= MAX_ADDR as reads: after 8 bits, drive cipo with the addressed register MSB first, changing on synchronized sclk falling edges; cipo = 0 while ncs is high; no frame_err for a valid read.
REQ-028 SHALL, when SPI_READBACK_EN is undefined, tie cipo to 0 and discard R/W = 0 frames with a frame_err pulse.

Verification
REQ-029 SHALL cover: reset, then check all outputs -> all 0x00, cipo = 0.
REQ-030 SHALL cover: write frame 0x80F0 (addr 0, data 0xF0) -> en_reg_out_7_0 = 0xF0 within 3 clk of ncs rise, one wr_strobe, others unchanged.
REQ-031 SHALL cover: write 0x8480 (addr 4, duty 0x80), then 0x85AA (addr 5) -> pwm_duty_cycle = 0x80, frame_err pulses once, nothing else changes.
REQ-032 SHALL cover: 15-bit frame and 17-bit frame to addr 1 -> en_reg_out_15_8 unchanged, one frame_err pulse each.
REQ-033 SHALL cover: reset asserted after 8 bits of 0x8355 -> en_reg_pwm_15_8 = 0x00, no wr_strobe.
REQ-034 SHALL cover, with SPI_READBACK_EN: write 0x823C, then read frame 0x0200 -> cipo shifts out 0x3C MSB first during bits 8-15.

Source files
------------

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI register-write target feeding the PWM block.
// Five 8-bit registers at addresses 0x00-0x04, written by 16-bit frames
// {rw, addr[6:0], data[7:0]} sent MSB first. All SPI pins are asynchronous
// and are sampled into the clk domain; clk must run at least 4x sclk.
// Optional feature: define SPI_READBACK_EN to answer rw=0 frames on cipo.
module spi_peripheral #(
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);
    localparam logic [6:0] NUM_REGS = 7'd5;

    logic [2:0]  sclk_q;
    logic [2:0]  ncs_q;
    logic [1:0]  copi_q;
    logic        sclk_rise, ncs_fall, ncs_rise, ncs_s, copi_s;

    logic        in_frame;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic        ovf;
    logic [7:0]  regs [0:4];

    logic        len_ok, rw, addr_ok, wr_ok, rd_valid, do_commit, do_err;
    logic [6:0]  addr;

    // Two synchronizer flops per pin, plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            ncs_q  <= '0;
            copi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ncs_q  <= {ncs_q[1:0], ncs};
            copi_q <= {copi_q[0], copi};
        end
    end

    assign ncs_s     = ncs_q[1];
    assign copi_s    = copi_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];

    // Frame capture. in_frame is only set by a real falling edge, so a frame
    // cut by reset, or ncs already low at reset release, is never evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ovf      <= 1'b0;
        end else if (ncs_fall) begin
            in_frame <= 1'b1;
            bit_cnt  <= '0;
            shreg    <= '0;
            ovf      <= 1'b0;
        end else if (ncs_rise) begin
            in_frame <= 1'b0;
        end else if (in_frame && !ncs_s && sclk_rise) begin
            shreg <= {shreg[14:0], copi_s};
            if (bit_cnt == 5'd16) ovf <= 1'b1;
            else                  bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign rw      = shreg[15];
    assign addr    = shreg[14:8];
    assign len_ok  = (bit_cnt == 5'd16) && !ovf;
    assign addr_ok = (addr <= MAX_A);
    assign wr_ok   = len_ok && rw && addr_ok;
`ifdef SPI_READBACK_EN
    assign rd_valid = len_ok && !rw && addr_ok;
`else
    assign rd_valid = 1'b0;
`endif
    assign do_commit = ncs_rise && in_frame && wr_ok;
    assign do_err    = ncs_rise && in_frame && !wr_ok && !rd_valid;

    // Register file and the one-cycle commit / discard pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= do_commit;
            frame_err <= do_err;
            if (do_commit && addr < NUM_REGS) regs[addr[2:0]] <= shreg[7:0];
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
    logic       sclk_fall, rd_hit, tx_on, cipo_q;
    logic [7:0] rd_data, tx_sr;

    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    // Header byte is complete once 8 bits are in: shreg[7] = rw, [6:0] = addr.
    assign rd_hit    = !shreg[7] && (shreg[6:0] <= MAX_A);
    assign rd_data   = (shreg[6:0] < NUM_REGS) ? regs[shreg[2:0]] : 8'h00;

    // Read data leaves on falling sclk so the controller samples it on rising.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || ncs_s) begin
            cipo_q <= 1'b0;
            tx_on  <= 1'b0;
            tx_sr  <= '0;
        end else if (sclk_fall) begin
            if (bit_cnt == 5'd8 && !ovf) begin
                tx_on  <= rd_hit;
                cipo_q <= rd_hit & rd_data[7];
                tx_sr  <= {rd_data[6:0], 1'b0};
            end else if (tx_on && bit_cnt < 5'd16) begin
                cipo_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
            end else begin
                cipo_q <= 1'b0;
                tx_on  <= 1'b0;
            end
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized and directed frames against a register-file
// model; checks register values 3 clk after ncs rises, pulse counts and cipo.
module tb_spi_peripheral;
    localparam int MAX_ADDR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;
    logic       wr_strobe, frame_err;

    int checks = 0;
    int failures = 0;
    int ws_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] m [5];
    logic [7:0] rx;

    spi_peripheral #(.MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
        .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe) ws_cnt++;
        if (frame_err) fe_cnt++;
    end

    function automatic logic [39:0] model_regs();
        return {m[0], m[1], m[2], m[3], m[4]};
    endfunction

    // Clock n bits of w (MSB first) with sclk period 80 ns; rx keeps the last
    // 8 cipo samples taken at rising sclk.
    task automatic sclk_bits(input logic [31:0] w, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            copi = w[i];
            #40 sclk = 1'b1;
            r = {r[6:0], cipo};
            #40 sclk = 1'b0;
        end
    endtask

    // Whole frame; returns 3 rising clk edges (+1) after ncs rises.
    task automatic send_frame(input logic [31:0] w, input int n, output logic [7:0] r);
        ws_cnt = 0;
        fe_cnt = 0;
        ncs = 1'b0;
        #80;
        sclk_bits(w, n, r);
        #80;
        @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        checks++;
        if ({r0, r1, r2, r3, r4} !== 40'h0) begin
            failures++;
            $display("FAIL reset_regs got=%h want=%h", {r0, r1, r2, r3, r4}, 40'h0);
        end
        checks++;
        if ({cipo, wr_strobe, frame_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_bits got=%b want=000", {cipo, wr_strobe, frame_err});
        end
        @(negedge clk);
        rst = 1'b0;
        settle();
        checks++;
        if (ws_cnt != 0 || fe_cnt != 0) begin
            failures++;
            $display("FAIL reset_release_pulses got ws=%0d fe=%0d want 0/0", ws_cnt, fe_cnt);
        end
        ws_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic test_write_basic();
        send_frame(32'h80F0, 16, rx);
        m[0] = 8'hF0;
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs()) begin
            failures++;
            $display("FAIL basic_regs got=%h want=%h", {r0, r1, r2, r3, r4}, model_regs());
        end
        settle();
        checks++;
        if (ws_cnt != 1 || fe_cnt != 0) begin
            failures++;
            $display("FAIL basic_pulses got ws=%0d fe=%0d want 1/0", ws_cnt, fe_cnt);
        end
        checks++;
        if (rx !== 8'h00) begin
            failures++;
            $display("FAIL basic_cipo got=%h want=00", rx);
        end
    endtask

    task automatic test_addr_range();
        send_frame(32'h8480, 16, rx);
        m[4] = 8'h80;
        settle();
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs() || ws_cnt != 1 || fe_cnt != 0) begin
            failures++;
            $display("FAIL addr4 got regs=%h ws=%0d fe=%0d want regs=%h ws=1 fe=0",
                     {r0, r1, r2, r3, r4}, ws_cnt, fe_cnt, model_regs());
        end
        send_frame(32'h85AA, 16, rx);
        settle();
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs()) begin
            failures++;
            $display("FAIL addr5_regs got=%h want=%h", {r0, r1, r2, r3, r4}, model_regs());
        end
        checks++;
        if (ws_cnt != 0 || fe_cnt != 1) begin
            failures++;
            $display("FAIL addr5_pulses got ws=%0d fe=%0d want 0/1", ws_cnt, fe_cnt);
        end
    endtask

    task automatic test_bad_length();
        // 15 bits: the first 15 bits of 0x8177
        send_frame(32'h8177 >> 1, 15, rx);
        settle();
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs() || ws_cnt != 0 || fe_cnt != 1) begin
            failures++;
            $display("FAIL short_frame got regs=%h ws=%0d fe=%0d want regs=%h ws=0 fe=1",
                     {r0, r1, r2, r3, r4}, ws_cnt, fe_cnt, model_regs());
        end
        // 17 bits: 0x8177 followed by one extra bit
        send_frame({15'h0, 16'h8177, 1'b1}, 17, rx);
        settle();
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs() || ws_cnt != 0 || fe_cnt != 1) begin
            failures++;
            $display("FAIL long_frame got regs=%h ws=%0d fe=%0d want regs=%h ws=0 fe=1",
                     {r0, r1, r2, r3, r4}, ws_cnt, fe_cnt, model_regs());
        end
    endtask

    task automatic test_random();
        int n, exp_ws, exp_fe;
        logic rw, ok, rd;
        logic [6:0] a;
        logic [7:0] d, exp_rx;
        logic [15:0] w16;
        logic [31:0] w;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0: n = 15;
                1: n = 17;
                default: n = 16;
            endcase
            rw = ($urandom_range(0, 3) != 0);
            a = 7'($urandom_range(0, 7));
            d = 8'($urandom);
            w16 = {rw, a, d};
            if (n == 15) w = {16'h0, w16} >> 1;
            else if (n == 17) w = {15'h0, w16, 1'($urandom_range(0, 1))};
            else w = {16'h0, w16};
            ok = (n == 16) && rw && (int'(a) <= MAX_ADDR);
`ifdef SPI_READBACK_EN
            rd = (n == 16) && !rw && (int'(a) <= MAX_ADDR);
            exp_rx = (rd && a < 5) ? m[a] : 8'h00;
`else
            rd = 1'b0;
            exp_rx = 8'h00;
`endif
            exp_ws = ok ? 1 : 0;
            exp_fe = (ok || rd) ? 0 : 1;
            send_frame(w, n, rx);
            if (ok && a < 5) m[a] = d;
            checks++;
            if ({r0, r1, r2, r3, r4} !== model_regs()) begin
                failures++;
                $display("FAIL rand%0d_regs frame=%h n=%0d got=%h want=%h",
                         it, w, n, {r0, r1, r2, r3, r4}, model_regs());
            end
            settle();
            checks++;
            if (ws_cnt != exp_ws || fe_cnt != exp_fe) begin
                failures++;
                $display("FAIL rand%0d_pulses frame=%h n=%0d got ws=%0d fe=%0d want %0d/%0d",
                         it, w, n, ws_cnt, fe_cnt, exp_ws, exp_fe);
            end
            if (n == 16) begin
                checks++;
                if (rx !== exp_rx) begin
                    failures++;
                    $display("FAIL rand%0d_cipo frame=%h got=%h want=%h", it, w, rx, exp_rx);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        ws_cnt = 0;
        fe_cnt = 0;
        ncs = 1'b0;
        #80;
        sclk_bits(32'h83, 8, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        #40;
        sclk_bits(32'h55, 8, rx);
        #80;
        @(negedge clk);
        ncs = 1'b1;
        settle();
        checks++;
        if (r3 !== 8'h00 || {r0, r1, r2, r3, r4} !== model_regs()) begin
            failures++;
            $display("FAIL midreset_regs got=%h want=%h", {r0, r1, r2, r3, r4}, model_regs());
        end
        checks++;
        if (ws_cnt != 0) begin
            failures++;
            $display("FAIL midreset_strobe got=%0d want=0", ws_cnt);
        end
        // A fresh frame after the aborted one must work normally.
        send_frame(32'h8355, 16, rx);
        m[3] = 8'h55;
        settle();
        checks++;
        if ({r0, r1, r2, r3, r4} !== model_regs() || ws_cnt != 1) begin
            failures++;
            $display("FAIL post_reset_write got regs=%h ws=%0d want regs=%h ws=1",
                     {r0, r1, r2, r3, r4}, ws_cnt, model_regs());
        end
    endtask

`ifdef SPI_READBACK_EN
    task automatic test_readback();
        send_frame(32'h823C, 16, rx);
        m[2] = 8'h3C;
        settle();
        send_frame(32'h0200, 16, rx);
        settle();
        checks++;
        if (rx !== 8'h3C || fe_cnt != 0 || ws_cnt != 0) begin
            failures++;
            $display("FAIL readback got rx=%h fe=%0d ws=%0d want rx=3c fe=0 ws=0",
                     rx, fe_cnt, ws_cnt);
        end
        checks++;
        if (cipo !== 1'b0) begin
            failures++;
            $display("FAIL readback_idle got=%b want=0", cipo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_addr_range();
        test_bad_length();
`ifdef SPI_READBACK_EN
        test_readback();
`endif
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
